// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared LED mode encoding for led_pattern_ctrl and its channels
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_SOLID   = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_BREATHE = 2'b11
    } led_mode_t;

endpackage

// File: rtl/led_pattern_ctrl_if.sv
// rtl/led_pattern_ctrl_if.sv - channel configuration write port (valid/ready plus error pulse)
interface led_pattern_ctrl_if #(
    parameter int PWM_BITS  = 8,
    parameter int HALF_BITS = 16
);
    logic                 i_cfg_valid;
    logic                 o_cfg_ready;
    logic [3:0]           i_cfg_ch;
    logic [1:0]           i_cfg_mode;
    logic [HALF_BITS-1:0] i_cfg_half;
    logic [PWM_BITS-1:0]  i_cfg_duty;
    logic                 o_cfg_err;

    modport slave (
        input  i_cfg_valid, i_cfg_ch, i_cfg_mode, i_cfg_half, i_cfg_duty,
        output o_cfg_ready, o_cfg_err
    );

    modport master (
        output i_cfg_valid, i_cfg_ch, i_cfg_mode, i_cfg_half, i_cfg_duty,
        input  o_cfg_ready, o_cfg_err
    );
endinterface

// File: rtl/led_channel.sv
// rtl/led_channel.sv - one LED channel: config regs, blink phase, breathe ramp, level output
module led_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS  = 8,
    parameter int HALF_BITS = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_tick,
    input  logic                 i_load,
    input  led_mode_t            i_mode,
    input  logic [HALF_BITS-1:0] i_half,
    input  logic [PWM_BITS-1:0]  i_duty,
    output logic [PWM_BITS-1:0]  o_level
);

    led_mode_t            r_mode;
    logic [HALF_BITS-1:0] r_half;
    logic [HALF_BITS-1:0] r_count;
    logic [PWM_BITS-1:0]  r_duty;
    logic [PWM_BITS-1:0]  r_ramp;
    logic                 r_phase;
    logic                 r_rising;

    logic [HALF_BITS-1:0] w_half_last;

    // A half-period of 0 behaves as 1 tick.
    assign w_half_last = (r_half == '0) ? '0 : r_half - 1'b1;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_mode   <= MODE_OFF;
            r_half   <= HALF_BITS'(1);
            r_duty   <= '0;
            r_count  <= '0;
            r_ramp   <= '0;
            r_phase  <= 1'b0;
            r_rising <= 1'b0;
        end else if (i_load) begin
            // Every write restarts the pattern from its beginning.
            r_mode   <= i_mode;
            r_half   <= i_half;
            r_duty   <= i_duty;
            r_count  <= '0;
            r_ramp   <= '0;
            r_phase  <= 1'b1;
            r_rising <= 1'b1;
        end else if (i_tick) begin
            if (r_count >= w_half_last) begin
                r_count <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_count <= r_count + 1'b1;
            end

            if (r_duty == '0) begin
                r_ramp <= '0;
            end else if (r_rising) begin
                r_ramp <= r_ramp + 1'b1;
                if (r_ramp == r_duty - 1'b1) begin
                    r_rising <= 1'b0;
                end
            end else begin
                r_ramp <= r_ramp - 1'b1;
                if (r_ramp == PWM_BITS'(1)) begin
                    r_rising <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_level = '0;
        case (r_mode)
            MODE_OFF:     o_level = '0;
            MODE_SOLID:   o_level = r_duty;
            MODE_BLINK:   o_level = r_phase ? r_duty : '0;
            MODE_BREATHE: o_level = r_ramp;
            default:      o_level = '0;
        endcase
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - multi-channel LED driver with shared prescaler and PWM counter
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int TICK_DIV  = 25,
    parameter int PWM_BITS  = 8,
    parameter int HALF_BITS = 16
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_enable,
    led_pattern_ctrl_if.slave   cfg,
    output logic [N_CH-1:0]     o_led
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PRE_W-1:0]     r_presc;
    logic [PWM_BITS-1:0]  r_pwm;
    logic                 r_ready;
    logic                 r_err;
    logic [N_CH-1:0]      r_wr_en;
    led_mode_t            r_wr_mode;
    logic [HALF_BITS-1:0] r_wr_half;
    logic [PWM_BITS-1:0]  r_wr_duty;
    logic [N_CH-1:0]      r_led;

    logic                 w_tick;
    logic                 w_accept;
    logic [PWM_BITS-1:0]  w_level [N_CH];
    logic [N_CH-1:0]      w_lit;

    assign w_tick   = (r_presc == PRE_W'(TICK_DIV - 1));
    assign w_accept = cfg.i_cfg_valid & r_ready;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_presc <= '0;
            r_pwm   <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            r_pwm   <= r_pwm + 1'b1;
        end
    end

    // Ready drops for exactly one cycle after each accepted write; the write
    // is staged one cycle so channels load on the edge after acceptance.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_wr_en   <= '0;
            r_wr_mode <= MODE_OFF;
            r_wr_half <= '0;
            r_wr_duty <= '0;
        end else begin
            r_ready <= ~w_accept;
            r_err   <= w_accept && (int'(cfg.i_cfg_ch) >= N_CH);
            for (int n = 0; n < N_CH; n++) begin
                r_wr_en[n] <= w_accept && (int'(cfg.i_cfg_ch) == n);
            end
            if (w_accept) begin
                r_wr_mode <= led_mode_t'(cfg.i_cfg_mode);
                r_wr_half <= cfg.i_cfg_half;
                r_wr_duty <= cfg.i_cfg_duty;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        led_channel #(
            .PWM_BITS  (PWM_BITS),
            .HALF_BITS (HALF_BITS)
        ) u_ch (
            .i_clock (i_clock),
            .i_reset (i_reset),
            .i_tick  (w_tick),
            .i_load  (r_wr_en[g]),
            .i_mode  (r_wr_mode),
            .i_half  (r_wr_half),
            .i_duty  (r_wr_duty),
            .o_level (w_level[g])
        );
    end

    // Full-scale level is always lit so it never shows a one-clock dropout.
    always_comb begin
        w_lit = '0;
        for (int n = 0; n < N_CH; n++) begin
            w_lit[n] = (r_pwm < w_level[n]) | (&w_level[n]);
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_led <= '0;
        end else begin
            r_led <= w_lit & {N_CH{i_enable}};
        end
    end

    assign o_led           = r_led;
    assign cfg.o_cfg_ready = r_ready;
    assign cfg.o_cfg_err   = r_err;

endmodule
